// File: rtl/mcycle_muldiv_if.sv
// rtl/mcycle_muldiv_if.sv - request/result bundle between EX stage and the multi-cycle mul/div unit
interface mcycle_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;
    logic [1:0]       MulFlags;
    logic             DivByZero;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done, MulFlags, DivByZero
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done, MulFlags, DivByZero
    );
endinterface

// File: rtl/mcycle_muldiv.sv
// rtl/mcycle_muldiv.sv - iterative shift-add multiplier / restoring divider, fixed WIDTH-cycle latency
module mcycle_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           CLK,
    input logic           Reset,
    mcycle_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [1:0]         op;
    logic               sign1, sign2;
    logic [WIDTH-1:0]   dividend_raw;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic [WIDTH-1:0]   result1, result2;
    logic [1:0]         flags;
    logic               div_zero;

    logic               accept, last_step;
    logic [WIDTH-1:0]   mag1, mag2;

    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               negate;

    assign accept    = bus.Start && (state == IDLE || state == DONE);
    assign last_step = (state == COMPUTE) && (count == CNT_W'(WIDTH - 1));

    assign mag1 = (bus.MCycleOp[0] && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
    assign mag2 = (bus.MCycleOp[0] && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = COMPUTE;
            COMPUTE: if (last_step) state_next = DONE;
            DONE:    state_next = bus.Start ? COMPUTE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration: mul adds the multiplicand on multiplier LSB then shifts right;
    // div shifts the remainder left and subtracts the divisor when it fits.
    always_comb begin
        mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? b_mag : {WIDTH{1'b0}})};
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_mag};
        if (op[1]) begin
            step_hi = div_ge ? (div_shift - {1'b0, b_mag}) : div_shift;
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        negate   = op[0] && (sign1 ^ sign2);
        product  = {step_hi[WIDTH-1:0], step_lo};
        prod_fix = negate ? -product : product;
        quo_fix  = negate ? -step_lo : step_lo;
        rem_fix  = (op[0] && sign1) ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            count        <= '0;
            op           <= '0;
            sign1        <= 1'b0;
            sign2        <= 1'b0;
            dividend_raw <= '0;
            b_mag        <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            result1      <= '0;
            result2      <= '0;
            flags        <= '0;
            div_zero     <= 1'b0;
        end else begin
            if (accept) begin
                count        <= '0;
                op           <= bus.MCycleOp;
                sign1        <= bus.Operand1[WIDTH-1];
                sign2        <= bus.Operand2[WIDTH-1];
                dividend_raw <= bus.Operand1;
                b_mag        <= bus.MCycleOp[1] ? mag2 : mag1;
                acc_hi       <= '0;
                acc_lo       <= bus.MCycleOp[1] ? mag1 : mag2;
            end else if (state == COMPUTE) begin
                count  <= count + 1'b1;
                acc_hi <= step_hi;
                acc_lo <= step_lo;
            end
            if (last_step) begin
                if (!op[1]) begin
                    result1  <= prod_fix[WIDTH-1:0];
                    result2  <= prod_fix[2*WIDTH-1:WIDTH];
                    flags    <= {prod_fix[2*WIDTH-1], prod_fix == '0};
                    div_zero <= 1'b0;
                end else if (b_mag == '0) begin
                    result1  <= '1;
                    result2  <= dividend_raw;
                    flags    <= 2'b10;
                    div_zero <= 1'b1;
                end else begin
                    result1  <= quo_fix;
                    result2  <= rem_fix;
                    flags    <= {quo_fix[WIDTH-1], quo_fix == '0};
                    div_zero <= 1'b0;
                end
            end
        end
    end

    assign bus.Busy      = (state == COMPUTE);
    assign bus.Done      = (state == DONE);
    assign bus.Result1   = result1;
    assign bus.Result2   = result2;
    assign bus.MulFlags  = flags;
    assign bus.DivByZero = div_zero;
endmodule

// File: tb/tb_mcycle_muldiv.sv
// tb/tb_mcycle_muldiv.sv - vector table plus scoreboard bench for mcycle_muldiv
module tb_mcycle_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcycle_muldiv_if #(.WIDTH(W)) bus ();
    mcycle_muldiv #(.WIDTH(W), .CNT_W(6)) dut (.CLK(clk), .Reset(rst), .bus(bus));

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, r1, r2;
        logic [1:0]   flags;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] r1, r2;
        logic [1:0]   flags;
        logic         dbz;
        int           issue;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [63:0] p;
        e.dbz = 1'b0;
        e.issue = 0;
        if (!op[1]) begin
            if (op[0]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else       p = {32'b0, a} * {32'b0, b};
            e.r1 = p[31:0];
            e.r2 = p[63:32];
            e.flags = {p[63], p == 64'd0};
        end else begin
            if (b == 0) begin
                e.r1 = '1; e.r2 = a; e.dbz = 1'b1;
            end else if (!op[0]) begin
                e.r1 = a / b; e.r2 = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.r1 = a; e.r2 = 0;
            end else begin
                e.r1 = $signed(a) / $signed(b);
                e.r2 = $signed(a) % $signed(b);
            end
            e.flags = {e.r1[31], e.r1 == 0};
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.Done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got Done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result1", 64'(bus.Result1), 64'(e.r1));
                check("result2", 64'(bus.Result2), 64'(e.r2));
                check("mulflags", 64'(bus.MulFlags), 64'(e.flags));
                check("divbyzero", 64'(bus.DivByZero), 64'(e.dbz));
                check("latency", 64'(cyc - e.issue), 64'(W));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit track);
        bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
        if (track) begin
            e.issue = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        issue(op, a, b, e, 1'b1);
        @(negedge clk);
        bus.Start = 1'b0;
        drain();
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 2'b10, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 2'b10, 1'b0};
        vecs[2]  = '{2'b01, 32'd0,         32'd5,         32'd0,         32'd0,         2'b01, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b10, 1'b0};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         2'b10, 1'b0};
        vecs[5]  = '{2'b10, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       2'b10, 1'b1};
        vecs[6]  = '{2'b00, 32'd3,         32'd5,         32'd15,        32'd0,         2'b00, 1'b0};
        vecs[7]  = '{2'b10, 32'd100,       32'd7,         32'd14,        32'd2,         2'b00, 1'b0};
        vecs[8]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         2'b10, 1'b0};
        vecs[9]  = '{2'b10, 32'd5,         32'd10,        32'd0,         32'd5,         2'b01, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF8, 2'b10, 1'b1};
        vecs[11] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'd0,         32'h4000_0000, 2'b00, 1'b0};

        bus.Start = 1'b0; bus.MCycleOp = 2'b00; bus.Operand1 = '0; bus.Operand2 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_result1", 64'(bus.Result1), 64'd0);
        check("reset_result2", 64'(bus.Result2), 64'd0);
        check("reset_flags", 64'({bus.MulFlags, bus.DivByZero}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            e.r1 = vecs[i].r1; e.r2 = vecs[i].r2; e.flags = vecs[i].flags; e.dbz = vecs[i].dbz;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 12; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = (i == 5) ? 32'd0 : $urandom();
            run_op(op, a, b, model(op, a, b));
        end

        // Reset partway through a computation: no Done may follow, state fully cleared.
        @(negedge clk);
        issue(2'b00, 32'd1234, 32'd5678, e, 1'b0);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 64'(bus.Busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(bus.Busy), 64'd0);
        check("midreset_done", 64'(bus.Done), 64'd0);
        check("midreset_result1", 64'(bus.Result1), 64'd0);
        check("midreset_result2", 64'(bus.Result2), 64'd0);
        rst = 1'b0;
        run_op(2'b00, 32'd1234, 32'd5678, model(2'b00, 32'd1234, 32'd5678));

        // Start held high with operands changing every cycle: accepted once per 33 cycles.
        for (int k = 0; k < 3 * (W + 1); k++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = $urandom();
            issue(op, a, b, model(op, a, b), (k % (W + 1)) == 0);
        end
        @(negedge clk);
        bus.Start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
